// File: rtl/score_bcd_formatter_pkg.sv
// Shared constants and types for the score-to-BCD display formatter.
// Holds the digit geometry, clamp limit, FSM encoding and display-bus reset values.
package score_bcd_formatter_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;

    localparam logic [31:0] BCD_MAX = 32'd99_999_999;

    // Display bus after reset shows a single "0".
    localparam logic [31:0] RST_DATA = 32'h0000_0000;
    localparam logic [7:0]  RST_MASK = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // True when a BCD digit is not zero; drives the leading-zero mask.
    function automatic logic digit_nonzero(input logic [DIGIT_W-1:0] digit);
        return (digit != 4'd0);
    endfunction

endpackage

// File: rtl/score_bcd_formatter_bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: values of 5 or more get +3
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust
    import score_bcd_formatter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    // Conditional add-3 on a single nibble.
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/score_bcd_formatter.sv
// Sequential binary-to-BCD converter feeding the 8-digit seven-segment scanner.
// Display outputs only change in the single COMMIT cycle, never mid-conversion.
module score_bcd_formatter
    import score_bcd_formatter_pkg::*;
#(
    parameter int DATA_W   = 27,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       output_data,
    output logic [7:0]        output_valid,
    output logic              out_done,
    output logic              out_sat
);

    localparam int CNT_W = 6;

    state_t            state_r;
    logic [DATA_W-1:0] bin_r;
    logic [31:0]       bcd_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sat_r;

    logic [31:0]       bcd_adj_s;
    logic [7:0]        mask_s;
    logic [32:0]       in_ext_s;
    logic              clamp_s;
    logic              accept_s;
    logic              unused_top_s;

    assign in_ready = (state_r == IDLE) && !rst;
    assign accept_s = in_valid && in_ready;

    // One spare zero bit keeps the extension legal for DATA_W = 32.
    assign in_ext_s = {{(33 - DATA_W){1'b0}}, in_value};
    assign clamp_s  = (in_ext_s > {1'b0, BCD_MAX});

    // The top adjusted bit is shifted out; BCD_MAX never reaches it.
    assign unused_top_s = bcd_adj_s[31];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (bcd_r[DIGIT_W*g +: DIGIT_W]),
            .adjusted (bcd_adj_s[DIGIT_W*g +: DIGIT_W])
        );
    end

    // Leading-zero blanking mask computed from the finished accumulator.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        mask_s = 8'hFF;
        if (BLANK_EN) begin
            for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
                seen      = seen | digit_nonzero(bcd_r[DIGIT_W*i +: DIGIT_W]);
                mask_s[i] = seen;
            end
            mask_s[0] = 1'b1;
        end else begin
            mask_s = 8'hFF;
        end
    end

    // Conversion FSM with registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            bin_r        <= '0;
            bcd_r        <= 32'h0000_0000;
            cnt_r        <= '0;
            sat_r        <= 1'b0;
            output_data  <= RST_DATA;
            output_valid <= RST_MASK;
            out_done     <= 1'b0;
            out_sat      <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (clamp_s) begin
                            bin_r <= BCD_MAX[DATA_W-1:0];
                            sat_r <= 1'b1;
                        end else begin
                            bin_r <= in_value;
                            sat_r <= 1'b0;
                        end
                        bcd_r   <= 32'h0000_0000;
                        cnt_r   <= CNT_W'(DATA_W);
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    bcd_r <= {bcd_adj_s[30:0], bin_r[DATA_W-1]};
                    bin_r <= bin_r << 1;
                    cnt_r <= cnt_r - 6'd1;
                    if (cnt_r == 6'd1) begin
                        state_r <= COMMIT;
                    end
                end
                COMMIT: begin
                    output_data  <= bcd_r;
                    output_valid <= mask_s;
                    out_sat      <= sat_r;
                    out_done     <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_formatter.sv
// Scoreboard bench for score_bcd_formatter: drivers queue hand-computed results,
// per-instance monitors pop and compare on every out_done pulse.
module tb_score_bcd_formatter;
    import score_bcd_formatter_pkg::*;

    localparam int DW  = 27;
    localparam int LAT = DW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] val_a, val_b;
    logic          vld_a, vld_b;
    logic          rdy_a, rdy_b;
    logic [31:0]   data_a, data_b;
    logic [7:0]    mask_a, mask_b;
    logic          done_a, done_b, sat_a, sat_b;

    always #5 clk = ~clk;

    score_bcd_formatter #(.DATA_W(DW), .BLANK_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_value(val_a), .in_valid(vld_a), .in_ready(rdy_a),
        .output_data(data_a), .output_valid(mask_a), .out_done(done_a), .out_sat(sat_a)
    );

    score_bcd_formatter #(.DATA_W(DW), .BLANK_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .in_value(val_b), .in_valid(vld_b), .in_ready(rdy_b),
        .output_data(data_b), .output_valid(mask_b), .out_done(done_b), .out_sat(sat_b)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  mask;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   acc1, acc2, acc_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor for the blanking instance.
    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                flag("unexpected out_done A");
            end else begin
                e_a = q_a.pop_front();
                check("data A", data_a, e_a.data);
                check("mask A", mask_a, e_a.mask);
                check("sat A", sat_a, e_a.sat);
                check("latency A", cyc, e_a.cyc);
            end
        end
    end

    // Monitor for the non-blanking instance.
    always @(negedge clk) begin
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                flag("unexpected out_done B");
            end else begin
                e_b = q_b.pop_front();
                check("data B", data_b, e_b.data);
                check("mask B", mask_b, e_b.mask);
                check("sat B", sat_b, e_b.sat);
                check("latency B", cyc, e_b.cyc);
            end
        end
    end

    task automatic send(input bit sel, input logic [DW-1:0] v, input logic [31:0] d,
                        input logic [7:0] m, input logic s, input bit hold,
                        input bit want, output int acc);
        exp_t e;
        int   n;
        @(negedge clk);
        if (sel) begin val_b = v; vld_b = 1'b1; end
        else     begin val_a = v; vld_a = 1'b1; end
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            flag("accept timeout");
            acc = -1;
        end else begin
            acc    = cyc + 1;
            e.data = d;
            e.mask = m;
            e.sat  = s;
            e.cyc  = acc + LAT;
            if (want) begin
                if (sel) q_b.push_back(e);
                else     q_a.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            if (sel) vld_b = 1'b0;
            else     vld_a = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) flag("drain timeout");
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        vld_a = 1'b0; vld_b = 1'b0;
        val_a = '0;   val_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle done A", done_a, 1'b0);
        end
        check("reset data A", data_a, 32'h0000_0000);
        check("reset mask A", mask_a, 8'h01);
        check("reset sat A", sat_a, 1'b0);
        check("reset ready A", rdy_a, 1'b1);
        check("reset mask B", mask_b, 8'h01);

        // Basic conversion and in_ready window.
        send(1'b0, 27'd12345, 32'h0001_2345, 8'h1F, 1'b0, 1'b0, 1'b1, acc1);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("ready low in flight", rdy_a, 1'b0);
        end
        @(negedge clk);
        check("ready back", rdy_a, 1'b1);
        drain();

        // Back-to-back with in_valid held: interior zeros, then zero.
        send(1'b0, 27'd1005, 32'h0000_1005, 8'h0F, 1'b0, 1'b1, 1'b1, acc1);
        send(1'b0, 27'd0,    32'h0000_0000, 8'h01, 1'b0, 1'b0, 1'b1, acc2);
        check("b2b spacing", acc2 - acc1, DW + 2);
        drain();

        // Clamp and the exact limit.
        send(1'b0, 27'd123_456_789, 32'h9999_9999, 8'hFF, 1'b1, 1'b0, 1'b1, acc_x);
        send(1'b0, 27'd99_999_999,  32'h9999_9999, 8'hFF, 1'b0, 1'b0, 1'b1, acc_x);
        send(1'b0, 27'd10_000_000,  32'h1000_0000, 8'hFF, 1'b0, 1'b0, 1'b1, acc_x);
        drain();

        // No blanking instance.
        send(1'b1, 27'd7, 32'h0000_0007, 8'hFF, 1'b0, 1'b0, 1'b1, acc_x);
        drain();

        // Reset mid-conversion aborts without a done pulse.
        send(1'b0, 27'd4321, 32'h0000_4321, 8'h0F, 1'b0, 1'b0, 1'b0, acc_x);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset ready", rdy_a, 1'b1);
        check("post-reset data", data_a, 32'h0000_0000);
        check("post-reset mask", mask_a, 8'h01);
        check("post-reset sat", sat_a, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("no done after abort", done_a, 1'b0);
        end
        check("queue empty A", q_a.size(), 0);
        check("queue empty B", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_bcd_formatter.md
Name: score_bcd_formatter

Overview:
- Sits directly upstream of the 8-digit seven-segment scanner.
- Converts a binary game value (score, lives, stage number) into 8 packed BCD digits (`output_data`) and a per-digit enable mask (`output_valid`) with leading-zero blanking.
- Conversion is sequential: one shift-add-3 (double-dabble) step per cycle, behind a valid/ready handshake.
- Display outputs stay stable between conversions, so the scanner never shows a partial result.

Parameters:
- DATA_W, 27, width of `in_value`; legal range 4..32.
- BLANK_EN, 1, 1 = suppress leading zeros in `output_valid`; 0 = all eight digits always enabled.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_value  input  DATA_W  unsigned binary value to display
- in_valid  input  1  request to convert `in_value`
- in_ready  output  1  block can accept a request
- output_data  output  32  packed BCD; digit i occupies bits [4i+3:4i], digit 0 least significant
- output_valid  output  8  bit i = 1 means digit i is shown
- out_done  output  1  one-cycle pulse when new outputs are committed
- out_sat  output  1  last committed value was clamped

Behaviour:
- Reset and clocking:
  - Single clock domain; reset is synchronous and active-high.
  - Reset values: `output_data` = 32'h0000_0000, `output_valid` = 8'h01 (a lone "0"), `out_done` = 0, `out_sat` = 0, state = IDLE.
- States: IDLE, CONV, COMMIT.
- `in_ready` = (state == IDLE) && !rst.
- IDLE:
  - A request is accepted on a rising edge where `in_valid` && `in_ready`.
  - On accept, the value is compared to BCD_MAX (99_999_999).
  - If greater, load BCD_MAX and set the internal sat flag; otherwise load `in_value` zero-extended and clear the flag.
  - Clear the 32-bit BCD accumulator, load the step counter with DATA_W, go to CONV.
  - When DATA_W < 27 the clamp can never trigger.
- CONV:
  - Each cycle, every BCD nibble >= 5 gets +3.
  - Then {bcd, bin} shifts left by one and the counter decrements.
  - After exactly DATA_W steps, go to COMMIT.
  - `in_valid` is ignored (`in_ready` = 0).
- COMMIT (one cycle):
  - Register `output_data` = accumulator and `out_sat` = sat flag.
  - Register `output_valid`:
    - BLANK_EN = 1: bit i = 1 if digit i or any higher digit is non-zero; bit 0 is always 1.
    - BLANK_EN = 0: 8'hFF.
  - `out_done` = 1 for this cycle only; return to IDLE.
- Latency: accept at edge T; outputs and `out_done` change at edge T+DATA_W+1.
  - Next accept is possible at edge T+DATA_W+2.
  - Throughput is one conversion per DATA_W+2 cycles.
- Interior zeros stay visible (e.g. 1005 shows all four digits).
- Outputs hold their last committed value through IDLE and CONV; no intermediate accumulator value is ever visible.
- Simultaneous events:
  - `in_valid` held continuously: a new request is accepted in every IDLE cycle (back-to-back operation).
  - `in_valid` during COMMIT is not accepted; it is accepted in the next IDLE cycle if still high.
- Reset mid-operation (CONV or COMMIT): abort, apply reset values next edge, and produce no `out_done` pulse.
- `in_value` is sampled only at the accept edge; later changes have no effect on the conversion in flight.

Decomposition:
- Shared display package holds:
  - NUM_DIGITS = 8
  - BCD_MAX = 32'd99_999_999
  - state encodings IDLE = 2'd0, CONV = 2'd1, COMMIT = 2'd2
  - reset constants for the display bus: data 32'h0, mask 8'h01
- One natural sub-module, `bcd_digit_adjust`: combinational 4-bit "if >= 5 add 3"; instantiated 8 times by generate.
- Leading-zero mask logic stays inline.

Test Plan:
- Reset, then idle 10 cycles -> `output_data` = 32'h0, `output_valid` = 8'h01, `out_done` never high, `in_ready` = 1.
- `in_value` = 12345 accepted at edge T (DATA_W = 27) -> at edge T+28: `output_data` = 32'h0001_2345, `output_valid` = 8'h1F, `out_done` pulse 1 cycle, `out_sat` = 0; `in_ready` low T+1..T+28.
- `in_value` = 1005, then 0 back-to-back with `in_valid` held -> first result 32'h0000_1005 / 8'h0F; second 32'h0 / 8'h01; second accept exactly 29 cycles after first.
- `in_value` = 123_456_789 -> `output_data` = 32'h9999_9999, `output_valid` = 8'hFF, `out_sat` = 1; a following 99_999_999 -> same data, `out_sat` = 0.
- BLANK_EN = 0, `in_value` = 7 -> `output_data` = 32'h0000_0007, `output_valid` = 8'hFF.
- Accept 4321, assert `rst` 10 cycles later for 1 cycle -> no `out_done`, outputs = reset values, `in_ready` = 1 the cycle after `rst` deasserts.
